// File: rtl/rob_flush_ctrl.sv
// rob_flush_ctrl: mispredict recovery sequencer that walks squashed ROB entries youngest-first, frees their pregs, then truncates the ROB tail
module rob_flush_ctrl #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 5,
    parameter int PREG_W = 7
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mispredict,
    input  logic [TAG_W-1:0]  i_mispredict_tag,
    input  logic [TAG_W-1:0]  i_rob_head,
    input  logic [TAG_W-1:0]  i_rob_tail,
    output logic [TAG_W-1:0]  o_rd_idx,
    input  logic [PREG_W-1:0] i_rd_pd_new,
    input  logic              i_rd_has_dest,
    output logic              o_free_valid,
    output logic [PREG_W-1:0] o_free_preg,
    output logic              o_flush_valid,
    output logic [TAG_W-1:0]  o_flush_tag,
    output logic              o_rename_stall,
    output logic              o_busy
);
    typedef enum logic [1:0] {IDLE, WALK, TRUNC} state_t;

    // Tag arithmetic wraps modulo DEPTH, which may be narrower than the tag field
    localparam logic [TAG_W-1:0] MASK = TAG_W'(DEPTH - 1);
    localparam logic [TAG_W-1:0] ONE  = TAG_W'(1);

    state_t             r_state;
    logic [TAG_W-1:0]   r_ptr;
    logic [TAG_W-1:0]   r_stop;
    logic               r_busy;
    logic               r_flush_valid;
    logic [TAG_W-1:0]   r_flush_tag;

    logic [TAG_W-1:0]   w_n_idle;
    logic [TAG_W-1:0]   w_n_trunc;
    logic [TAG_W-1:0]   w_age_new;
    logic [TAG_W-1:0]   w_age_stop;
    logic               w_take;
    logic [TAG_W-1:0]   w_stop_eff;
    logic [TAG_W-1:0]   w_stop_next1;
    logic [TAG_W-1:0]   w_ptr_dec;
    logic               w_walk;

    // Squash counts, relative ages and the effective walk boundary for this cycle
    always_comb begin
        w_n_idle     = (i_rob_tail - i_mispredict_tag - ONE) & MASK;
        w_n_trunc    = (r_stop - i_mispredict_tag) & MASK;
        w_age_new    = (i_mispredict_tag - i_rob_head) & MASK;
        w_age_stop   = (r_stop - i_rob_head) & MASK;
        w_take       = i_mispredict && (w_age_new < w_age_stop);
        w_stop_eff   = (r_state == WALK && w_take) ? i_mispredict_tag : r_stop;
        w_stop_next1 = (w_stop_eff + ONE) & MASK;
        w_ptr_dec    = (r_ptr - ONE) & MASK;
        w_walk       = (r_state == WALK);
    end

    // Recovery FSM: IDLE -> (WALK) -> TRUNC -> IDLE, older mispredicts retarget the boundary
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_stop        <= '0;
            r_busy        <= 1'b0;
            r_flush_valid <= 1'b0;
            r_flush_tag   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_mispredict) begin
                        r_stop <= i_mispredict_tag;
                        r_ptr  <= (i_rob_tail - ONE) & MASK;
                        r_busy <= 1'b1;
                        if (w_n_idle != '0) begin
                            r_state <= WALK;
                        end else begin
                            r_state       <= TRUNC;
                            r_flush_valid <= 1'b1;
                            r_flush_tag   <= i_mispredict_tag;
                        end
                    end
                end
                WALK: begin
                    r_stop <= w_stop_eff;
                    if (r_ptr == w_stop_next1) begin
                        r_state       <= TRUNC;
                        r_flush_valid <= 1'b1;
                        r_flush_tag   <= w_stop_eff;
                    end else begin
                        r_ptr <= w_ptr_dec;
                    end
                end
                TRUNC: begin
                    r_flush_valid <= 1'b0;
                    r_flush_tag   <= '0;
                    if (w_take) begin
                        r_stop <= i_mispredict_tag;
                        r_ptr  <= r_stop;
                        if (w_n_trunc != '0) begin
                            r_state <= WALK;
                        end else begin
                            r_state       <= TRUNC;
                            r_flush_valid <= 1'b1;
                            r_flush_tag   <= i_mispredict_tag;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_busy        <= 1'b0;
                    r_flush_valid <= 1'b0;
                    r_flush_tag   <= '0;
                end
            endcase
        end
    end

    assign o_rd_idx       = r_ptr;
    assign o_free_valid   = w_walk & i_rd_has_dest;
    assign o_free_preg    = w_walk ? i_rd_pd_new : '0;
    assign o_flush_valid  = r_flush_valid;
    assign o_flush_tag    = r_flush_tag;
    assign o_busy         = r_busy;
    assign o_rename_stall = i_mispredict | r_busy;
endmodule

// File: tb/tb_rob_flush_ctrl.sv
// tb_rob_flush_ctrl: directed and random mispredict scenarios checked against a squash-list model
module tb_rob_flush_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       mispredict;
    logic [4:0] mtag, head, tail;
    logic [4:0] rd_idx;
    logic [6:0] pd_new;
    logic       has_dest;
    logic       free_valid;
    logic [6:0] free_preg;
    logic       flush_valid;
    logic [4:0] flush_tag;
    logic       stall, busy;

    logic [6:0] rob_pd [16];
    logic       rob_has[16];

    int tests = 0;
    int fails = 0;

    rob_flush_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mispredict(mispredict),
        .i_mispredict_tag(mtag), .i_rob_head(head), .i_rob_tail(tail),
        .o_rd_idx(rd_idx), .i_rd_pd_new(pd_new), .i_rd_has_dest(has_dest),
        .o_free_valid(free_valid), .o_free_preg(free_preg),
        .o_flush_valid(flush_valid), .o_flush_tag(flush_tag),
        .o_rename_stall(stall), .o_busy(busy)
    );

    always #5 clk = ~clk;

    assign pd_new   = rob_pd[rd_idx[3:0]];
    assign has_dest = rob_has[rd_idx[3:0]];

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    function automatic int age(input int x, input int h);
        return (x - h) & 15;
    endfunction

    function automatic int in_rob(input int h, input int t);
        int occ;
        occ = (t - h) & 15;
        if (occ == 0) occ = 16;
        return (h + $urandom_range(0, occ - 1)) & 15;
    endfunction

    task automatic fill_rob();
        for (int i = 0; i < 16; i++) begin
            rob_pd[i]  = 7'($urandom);
            rob_has[i] = 1'($urandom_range(0, 3) != 0);
        end
    endtask

    // Model: the squashed entries are simply everything younger than the oldest accepted branch, youngest first
    task automatic run_case(input string nm, input int h, input int t, input int g,
                            input int nj, input int nt, input int tt);
        int kind[$];
        int val[$];
        int fin, n0, fpos, e, frees_exp, frees_obs, k, v;
        n0  = (t - g - 1) & 15;
        fin = g;
        if (nj > 0 && nj <= n0 && age(nt, h) < age(g, h)) fin = nt;
        for (e = (t - 1) & 15; e != fin; e = (e - 1) & 15) begin kind.push_back(0); val.push_back(e); end
        kind.push_back(1); val.push_back(fin);
        fpos = kind.size();
        if (tt >= 0 && age(tt, h) < age(fin, h)) begin
            for (e = fin; e != tt; e = (e - 1) & 15) begin kind.push_back(0); val.push_back(e); end
            kind.push_back(1); val.push_back(tt);
        end
        kind.push_back(2); val.push_back(0);
        frees_exp = 0;
        foreach (kind[i]) if (kind[i] == 0 && rob_has[val[i]]) frees_exp++;
        frees_obs = 0;
        @(negedge clk);
        head = 5'(h); tail = 5'(t); mispredict = 1'b1; mtag = 5'(g);
        #1;
        chk({nm, ":c0_stall"}, stall, 1);
        chk({nm, ":c0_busy"}, busy, 0);
        chk({nm, ":c0_flush"}, flush_valid, 0);
        for (int c = 1; c <= kind.size(); c++) begin
            @(negedge clk);
            mispredict = 1'b0;
            if (nj > 0 && c == nj) begin mispredict = 1'b1; mtag = 5'(nt); end
            else if (tt >= 0 && c == fpos) begin mispredict = 1'b1; mtag = 5'(tt); end
            #1;
            k = kind[c-1];
            v = val[c-1];
            if (free_valid) frees_obs++;
            chk({nm, ":busy"}, busy, k != 2);
            chk({nm, ":stall"}, stall, mispredict | (k != 2));
            chk({nm, ":flush_valid"}, flush_valid, k == 1);
            chk({nm, ":free_valid"}, free_valid, (k == 0) ? rob_has[v] : 1'b0);
            if (k == 0) begin
                chk({nm, ":rd_idx"}, rd_idx, v);
                chk({nm, ":free_preg"}, free_preg, rob_pd[v]);
            end
            if (k == 1) chk({nm, ":flush_tag"}, flush_tag, v);
        end
        mispredict = 1'b0;
        chk({nm, ":free_count"}, frees_obs, frees_exp);
    endtask

    initial begin
        int h, t, g, nj, nt, tt, n0, frees;
        rst_n = 1'b0; mispredict = 1'b0; mtag = '0; head = '0; tail = '0;
        for (int i = 0; i < 16; i++) begin rob_pd[i] = 7'(i); rob_has[i] = 1'b1; end
        #1;
        chk("rst:busy", busy, 0);
        chk("rst:stall", stall, 0);
        chk("rst:flush_valid", flush_valid, 0);
        chk("rst:free_valid", free_valid, 0);
        chk("rst:rd_idx", rd_idx, 0);
        chk("rst:flush_tag", flush_tag, 0);
        chk("rst:free_preg", free_preg, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-walk: 5 squashed entries, reset after 3 frees
        @(negedge clk);
        head = 5'd0; tail = 5'd6; mtag = 5'd0; mispredict = 1'b1;
        frees = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mispredict = 1'b0;
            #1;
            if (free_valid) frees++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst:frees_before", frees, 3);
        chk("midrst:busy", busy, 0);
        chk("midrst:stall", stall, 0);
        chk("midrst:free_valid", free_valid, 0);
        chk("midrst:flush_valid", flush_valid, 0);
        chk("midrst:rd_idx", rd_idx, 0);
        chk("midrst:flush_tag", flush_tag, 0);
        chk("midrst:free_preg", free_preg, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            chk("postrst:free_valid", free_valid, 0);
            chk("postrst:flush_valid", flush_valid, 0);
            chk("postrst:busy", busy, 0);
        end

        rob_pd[5] = 7'h25; rob_pd[4] = 7'h24; rob_pd[3] = 7'h23;
        run_case("no_wrap", 0, 6, 2, 0, 0, -1);
        run_case("youngest", 0, 4, 3, 0, 0, -1);
        fill_rob();
        rob_has[1] = 1'b1; rob_has[0] = 1'b0; rob_has[15] = 1'b1;
        run_case("wrap", 12, 2, 14, 0, 0, -1);
        fill_rob();
        run_case("nest_older", 0, 10, 6, 2, 3, -1);
        run_case("nest_younger", 0, 10, 6, 2, 8, -1);
        run_case("nest_last", 0, 10, 6, 3, 5, -1);
        for (int i = 0; i < 16; i++) rob_has[i] = 1'b1;
        run_case("full", 5, 5, 5, 0, 0, -1);
        fill_rob();
        run_case("trunc_older", 0, 10, 6, 0, 0, 2);
        run_case("trunc_younger", 0, 10, 6, 0, 0, 8);
        run_case("trunc_equal", 0, 10, 6, 0, 0, 6);

        for (int r = 0; r < 60; r++) begin
            fill_rob();
            h  = $urandom_range(0, 15);
            t  = $urandom_range(0, 15);
            g  = in_rob(h, t);
            n0 = (t - g - 1) & 15;
            nj = (n0 > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n0) : 0;
            nt = in_rob(h, t);
            tt = ($urandom_range(0, 2) == 0) ? in_rob(h, t) : -1;
            run_case($sformatf("rand%0d", r), h, t, g, nj, nt, tt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
